// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed driver for an 8-anode, active-low
// seven-segment display showing six BCD clock digits (hh:mm:ss).
// One digit is lit per slot. A short guard gap with all anodes off opens
// every slot to suppress ghosting. The digits are snapshotted once per
// frame so a frame never mixes old and new time. The separator decimal
// points on the minute and hour digits blink at 1 Hz.
// Optional build macro: LEAD_ZERO_BLANK_EN (blank a leading hours-tens zero).
module seg7_scan_driver #(
  parameter int DIGIT_TICKS    = 100_000,
  parameter int GUARD_TICKS    = 1_000,
  parameter int HALF_SEC_TICKS = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] s1,
  input  logic [3:0] s2,
  input  logic [3:0] m1,
  input  logic [3:0] m2,
  input  logic [3:0] h1,
  input  logic [3:0] h2,
  input  logic       blank,
  output logic [7:0] an,
  output logic [6:0] seg,
  output logic       dp
);

  localparam int NUM_DIGITS = 6;
  localparam int TICK_W     = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
  localparam int HALF_W     = (HALF_SEC_TICKS > 1) ? $clog2(HALF_SEC_TICKS) : 1;

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(DIGIT_TICKS - 1);
  localparam logic [TICK_W-1:0] GUARD_END = TICK_W'(GUARD_TICKS);
  localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(HALF_SEC_TICKS - 1);
  localparam logic [2:0]        IDX_LAST  = 3'(NUM_DIGITS - 1);

  // Scan and blink state
  logic [TICK_W-1:0] tick_reg;
  logic [TICK_W-1:0] tick_next;
  logic [2:0]        idx_reg;
  logic [2:0]        idx_next;
  logic [HALF_W-1:0] half_cnt_reg;
  logic [HALF_W-1:0] half_cnt_next;
  logic              colon_on_reg;
  logic              colon_on_next;

  // Frame snapshot of the six digits, index = scan slot
  logic [3:0] digit_in [NUM_DIGITS];
  logic [3:0] snap_reg [NUM_DIGITS];

  // Registered display outputs
  logic [7:0] an_reg;
  logic [7:0] an_next;
  logic [6:0] seg_reg;
  logic [6:0] seg_next;
  logic       dp_reg;
  logic       dp_next;

  // Decode helpers
  logic       slot_wrap;
  logic       frame_wrap;
  logic       in_guard;
  logic       lead_blank;
  logic [3:0] cur_digit;
  logic [7:0] an_slot;

  assign digit_in[0] = s1;
  assign digit_in[1] = s2;
  assign digit_in[2] = m1;
  assign digit_in[3] = m2;
  assign digit_in[4] = h1;
  assign digit_in[5] = h2;

  assign slot_wrap  = (tick_reg == TICK_LAST);
  assign frame_wrap = slot_wrap && (idx_reg == IDX_LAST);
  assign in_guard   = (GUARD_TICKS != 0) && (tick_reg < GUARD_END);

  // Slot tick counter and digit index, idx steps once per slot wrap
  always_comb begin
    tick_next = tick_reg + 1'b1;
    idx_next  = idx_reg;
    if (slot_wrap) begin
      tick_next = '0;
      idx_next  = (idx_reg == IDX_LAST) ? 3'd0 : idx_reg + 3'd1;
    end
  end

  // Blink half-period counter, free-running regardless of blank or scan
  always_comb begin
    half_cnt_next = half_cnt_reg + 1'b1;
    colon_on_next = colon_on_reg;
    if (half_cnt_reg == HALF_LAST) begin
      half_cnt_next = '0;
      colon_on_next = ~colon_on_reg;
    end
  end

  // Scan and blink state registers
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_reg     <= '0;
      idx_reg      <= '0;
      half_cnt_reg <= '0;
      colon_on_reg <= 1'b1;
    end else begin
      tick_reg     <= tick_next;
      idx_reg      <= idx_next;
      half_cnt_reg <= half_cnt_next;
      colon_on_reg <= colon_on_next;
    end
  end

  // Snapshot registers: reload all digits together on the last cycle of a frame
  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_snap
      always_ff @(posedge clk) begin
        if (rst) begin
          snap_reg[gi] <= 4'd0;
        end else if (frame_wrap) begin
          snap_reg[gi] <= digit_in[gi];
        end
      end
    end
  endgenerate

  // One-hot (active-high) anode for the current slot; an[7:6] are never selected
  generate
    for (genvar gi = 0; gi < 8; gi++) begin : g_anode
      if (gi < NUM_DIGITS) begin : g_used
        assign an_slot[gi] = (idx_reg == 3'(gi));
      end else begin : g_unused
        assign an_slot[gi] = 1'b0;
      end
    end
  endgenerate

  // Select the snapshot digit for the current slot
  always_comb begin
    cur_digit = 4'd0;
    case (idx_reg)
      3'd0:    cur_digit = snap_reg[0];
      3'd1:    cur_digit = snap_reg[1];
      3'd2:    cur_digit = snap_reg[2];
      3'd3:    cur_digit = snap_reg[3];
      3'd4:    cur_digit = snap_reg[4];
      3'd5:    cur_digit = snap_reg[5];
      default: cur_digit = 4'd0;
    endcase
  end

`ifdef LEAD_ZERO_BLANK_EN
  // A zero in the hours-tens position is suppressed for the whole slot
  assign lead_blank = (idx_reg == IDX_LAST) && (snap_reg[NUM_DIGITS-1] == 4'd0);
`else
  assign lead_blank = 1'b0;
`endif

  // Next display outputs from the current tick/idx/snapshot
  always_comb begin
    // BCD to {g,f,e,d,c,b,a}, active low; non-BCD codes show a dash
    case (cur_digit)
      4'd0:    seg_next = 7'h40;
      4'd1:    seg_next = 7'h79;
      4'd2:    seg_next = 7'h24;
      4'd3:    seg_next = 7'h30;
      4'd4:    seg_next = 7'h19;
      4'd5:    seg_next = 7'h12;
      4'd6:    seg_next = 7'h02;
      4'd7:    seg_next = 7'h78;
      4'd8:    seg_next = 7'h00;
      4'd9:    seg_next = 7'h10;
      default: seg_next = 7'h3F;
    endcase

    if (blank || in_guard) begin
      an_next = 8'hFF;
    end else begin
      an_next = ~an_slot;
    end

    if (lead_blank) begin
      an_next  = 8'hFF;
      seg_next = 7'h7F;
    end

    // Separator dots sit on the minute-ones and hour-ones digits
    dp_next = ~(((idx_reg == 3'd2) || (idx_reg == 3'd4)) && colon_on_reg);
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      an_reg  <= 8'hFF;
      seg_reg <= 7'h7F;
      dp_reg  <= 1'b1;
    end else begin
      an_reg  <= an_next;
      seg_reg <= seg_next;
      dp_reg  <= dp_next;
    end
  end

  assign an  = an_reg;
  assign seg = seg_reg;
  assign dp  = dp_reg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Testbench for seg7_scan_driver with small timing parameters.
// A cycle-count model predicts an/seg/dp every cycle; a few literal
// checks pin known points of the display sequence.
module tb_seg7_scan_driver;

  localparam int D = 4;   // DIGIT_TICKS
  localparam int G = 1;   // GUARD_TICKS
  localparam int H = 40;  // HALF_SEC_TICKS
  localparam int FRAME = 6 * D;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] s1, s2, m1, m2, h1, h2;
  logic       blank;
  logic [7:0] an;
  logic [6:0] seg;
  logic       dp;

  always #5 clk = ~clk;

  seg7_scan_driver #(
    .DIGIT_TICKS(D),
    .GUARD_TICKS(G),
    .HALF_SEC_TICKS(H)
  ) dut (
    .clk(clk),
    .rst(rst),
    .s1(s1),
    .s2(s2),
    .m1(m1),
    .m2(m2),
    .h1(h1),
    .h2(h2),
    .blank(blank),
    .an(an),
    .seg(seg),
    .dp(dp)
  );

  int total = 0;
  int bad   = 0;

  // Model state: mc = number of cycles elapsed since reset release
  int         mc = 0;
  bit         mvalid = 1'b0;
  logic [3:0] msnap [6];
  logic [7:0] exp_an;
  logic [6:0] exp_seg;
  logic       exp_dp;

  function automatic logic [6:0] seg_of(input logic [3:0] d);
    logic [6:0] tbl [10];
    tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    if (d > 4'd9) return 7'h3F;
    return tbl[d];
  endfunction

  // Model: the output after each edge is a function of the elapsed cycle count
  always @(posedge clk) begin : model
    int  tick;
    int  idx;
    bit  colon;
    if (rst) begin
      mc = 0;
      for (int i = 0; i < 6; i++) msnap[i] = 4'd0;
      exp_an  = 8'hFF;
      exp_seg = 7'h7F;
      exp_dp  = 1'b1;
      mvalid  = 1'b1;
    end else begin
      tick  = mc % D;
      idx   = (mc / D) % 6;
      colon = ((mc / H) % 2) == 0;
      exp_seg = seg_of(msnap[idx]);
      exp_an  = (blank || tick < G) ? 8'hFF : ~(8'h01 << idx);
`ifdef LEAD_ZERO_BLANK_EN
      if (idx == 5 && msnap[5] == 4'd0) begin
        exp_an  = 8'hFF;
        exp_seg = 7'h7F;
      end
`endif
      exp_dp = ((idx == 2 || idx == 4) && colon) ? 1'b0 : 1'b1;
      if (mc % FRAME == FRAME - 1) msnap = '{s1, s2, m1, m2, h1, h2};
      mc++;
    end
  end

  // Every-cycle compare against the model
  always @(negedge clk) begin
    if (mvalid) begin
      total++;
      if (an !== exp_an || seg !== exp_seg || dp !== exp_dp) begin
        bad++;
        $display("FAIL model_cmp mc=%0d an=%h seg=%h dp=%b required an=%h seg=%h dp=%b",
                 mc, an, seg, dp, exp_an, exp_seg, exp_dp);
      end
    end
  end

  task automatic lit(input string name, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s got=%h required=%h", name, act, req);
    end else begin
      $display("check %s = %h ok", name, act);
    end
  endtask

  // Advance until the model cycle count reaches target (bounded)
  task automatic run_to(input int target);
    int guard_cnt = 0;
    while (mc < target && guard_cnt < 2000) begin
      @(posedge clk);
      #2;
      guard_cnt++;
    end
    if (mc < target) begin
      total++;
      bad++;
      $display("FAIL run_to timeout mc=%0d required=%0d", mc, target);
    end
  endtask

  initial begin
    blank = 1'b0;
    s1 = 4'd1; s2 = 4'd2; m1 = 4'd3; m2 = 4'd4; h1 = 4'd5; h2 = 4'd6;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    lit("reset_an", an, 8'hFF);
    lit("reset_seg", {1'b0, seg}, 8'h7F);
    lit("reset_dp", {7'd0, dp}, 8'h01);
    @(posedge clk);
    #2 rst = 1'b0;

    // First frame shows zeros; slot 0 tick 1
    run_to(2);
    @(negedge clk);
    lit("f0_slot0_an", an, 8'hFE);
    lit("f0_slot0_seg", {1'b0, seg}, 8'h40);

    // Second frame shows snapshot 1..6
    run_to(26);
    @(negedge clk);
    lit("f1_slot0_an", an, 8'hFE);
    lit("f1_slot0_seg", {1'b0, seg}, 8'h79);
    run_to(34);
    @(negedge clk);
    lit("f1_slot2_an", an, 8'hFB);
    lit("f1_slot2_seg", {1'b0, seg}, 8'h30);
    lit("f1_slot2_dp_on", {7'd0, dp}, 8'h00);

    // Mid-frame change of s1 appears only from the next frame
    s1 = 4'd9;
    run_to(50);
    @(negedge clk);
    lit("f2_slot0_s1_9", {1'b0, seg}, 8'h10);
    run_to(58);
    @(negedge clk);
    lit("f2_slot2_dp_off", {7'd0, dp}, 8'h01);
    lit("f2_slot2_seg", {1'b0, seg}, 8'h30);

    // Non-BCD code shows a dash
    m1 = 4'hC;
    run_to(82);
    @(negedge clk);
    lit("f3_slot2_dash", {1'b0, seg}, 8'h3F);
    lit("f3_slot2_dp_on", {7'd0, dp}, 8'h00);

    // Blank for a full frame
    blank = 1'b1;
    run_to(90);
    @(negedge clk);
    lit("blank_an", an, 8'hFF);
    run_to(106);
    blank = 1'b0;

    // Leading zero on hours tens
    h2 = 4'd0;
    run_to(142);
    @(negedge clk);
`ifdef LEAD_ZERO_BLANK_EN
    lit("h2_zero_an", an, 8'hFF);
    lit("h2_zero_seg", {1'b0, seg}, 8'h7F);
`else
    lit("h2_zero_an", an, 8'hDF);
    lit("h2_zero_seg", {1'b0, seg}, 8'h40);
`endif

    // Reset in the middle of slot 3
    run_to(231);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    lit("midrst_an", an, 8'hFF);
    rst = 1'b0;
    run_to(2);
    @(negedge clk);
    lit("midrst_restart_an", an, 8'hFE);
    lit("midrst_restart_seg", {1'b0, seg}, 8'h40);
    run_to(60);

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Consumes the six BCD time digits (s1, s2, m1, m2, h1, h2) produced by the clock counter.
- Drives a time-multiplexed, active-low, 8-anode seven-segment display.
- Snapshots digits once per frame, scans one digit per slot with an anti-ghosting guard gap, and blinks the separator decimal points at 1 Hz.
- Sits between the clock core and the board display pins.

Parameters:
- DIGIT_TICKS, 100_000: clk cycles per digit slot (1 ms at 100 MHz); must be >= 2.
- GUARD_TICKS, 1_000: cycles at the start of each slot with all anodes off; must be < DIGIT_TICKS.
- HALF_SEC_TICKS, 50_000_000: clk cycles per separator blink half-period.

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  synchronous, active-high reset
- s1  in  4  seconds ones, BCD
- s2  in  4  seconds tens, BCD
- m1  in  4  minutes ones, BCD
- m2  in  4  minutes tens, BCD
- h1  in  4  hours ones, BCD
- h2  in  4  hours tens, BCD
- blank  in  1  1 = all anodes off; counters keep running
- an  out  8  anode enables, active low; an[0] = rightmost digit
- seg  out  7  segments {g,f,e,d,c,b,a}, active low
- dp  out  1  decimal point, active low

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high.
- Reset state: tick=0, idx=0, half_cnt=0, colon_on=1, snapshot=all 0, an=8'hFF, seg=7'h7F, dp=1.
- Slot counter: tick counts 0..DIGIT_TICKS-1, then wraps to 0. On the wrap cycle, idx advances 0→1→…→5→0.
- Slot-to-digit mapping: idx0=s1/an[0], idx1=s2/an[1], idx2=m1/an[2], idx3=m2/an[3], idx4=h1/an[4], idx5=h2/an[5]. an[7:6] are always 1.
- Frame snapshot: all six inputs are loaded into the snapshot on the cycle idx goes 5→0. Input changes mid-frame do not show until the next frame (no tearing). The first frame after reset displays zeros.
- Registered outputs, updated every cycle not in reset, from the current tick/idx (one-cycle latency):
  - an: 8'hFF if blank=1 or tick < GUARD_TICKS; otherwise ~(8'h01<<idx).
  - seg: decode of snapshot[idx]. Decode table: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10 (hex). Codes 10–15 give a dash, 7'h3F.
  - dp: 0 when idx∈{2,4} and colon_on=1; otherwise 1.
- Blink: half_cnt counts 0..HALF_SEC_TICKS-1; on wrap, colon_on toggles. It runs independently of blank and the slot counter.
- Reset mid-scan: all state returns to reset values on the next clk edge. The scan restarts at idx0, guard first.
- seg and dp are don't-care for correctness while an=8'hFF, but still follow the rules above.

Optional Feature:
- Macro: LEAD_ZERO_BLANK_EN.
- When defined: in slot idx5, if snapshot h2==0, seg=7'h7F and an stays 8'hFF for the whole slot.
- When undefined: h2 is always displayed, so 0 shows as 7'h40.

Test Plan (DIGIT_TICKS=4, GUARD_TICKS=1, HALF_SEC_TICKS=40):
- Reset release, inputs 1,2,3,4,5,6 (s1..h2) → first frame shows 7'h40 on each an. From the next frame, an cycles FE,FD,FB,F7,EF,DF with seg 79,24,30,19,12,02. an=FF for 1 cycle at the start of every slot.
- Change s1 from 1 to 9 while idx=2 → seg stays 79 on an[0] until after the 5→0 wrap, then shows 10.
- Input m1=4'hC → dash 7'h3F on an[2].
- Run 80 cycles → dp=0 in slots 2 and 4 for cycles 0–39, dp=1 in all slots for cycles 40–79, then repeats.
- blank=1 for one frame → an=FF throughout. After release, idx and half_cnt continue without re-syncing.
- h2=0 → an[5] low with seg 40 without the macro; an=FF for the whole slot 5 with LEAD_ZERO_BLANK_EN. Assert rst mid-slot 3 → an=FF next cycle, and the scan resumes at idx0.
